alu_op_sequencer: RTL and testbench

//  Control-step sequencer for register-register ALU instructions on the datapath.

---
 rtl/alu_op_sequencer_if.sv | 41 ++++
 rtl/alu_op_sequencer.sv | 179 +++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/alu_op_sequencer_if.sv
// Bundle between the IR/start source and the datapath control inputs of alu_op_sequencer.
// master drives start/ir/mem_ready; slave (the sequencer) drives every datapath strobe.
interface alu_op_sequencer_if #(
    parameter int NUM_REGS = 16,
    parameter int OPCODE_W = 5
);
    logic                start;
    logic [31:0]         ir;
    logic                mem_ready;
    logic [NUM_REGS-1:0] rin;
    logic [NUM_REGS-1:0] rout;
    logic                pc_out;
    logic                mar_in;
    logic                inc_pc;
    logic                pc_in;
    logic                read;
    logic                mdr_in;
    logic                mdr_out;
    logic                ir_in;
    logic                y_in;
    logic                z_in;
    logic                zlow_out;
    logic                zhigh_out;
    logic                lo_in;
    logic                hi_in;
    logic [OPCODE_W-1:0] opcode;
    logic                busy;
    logic                done;

    modport master (
        output start, ir, mem_ready,
        input  rin, rout, pc_out, mar_in, inc_pc, pc_in, read, mdr_in, mdr_out, ir_in,
               y_in, z_in, zlow_out, zhigh_out, lo_in, hi_in, opcode, busy, done
    );

    modport slave (
        input  start, ir, mem_ready,
        output rin, rout, pc_out, mar_in, inc_pc, pc_in, read, mdr_in, mdr_out, ir_in,
               y_in, z_in, zlow_out, zhigh_out, lo_in, hi_in, opcode, busy, done
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// Control-step sequencer (T0..T6) for register-register ALU ops, with HI/LO writeback for MUL/DIV.
// Latency: T0 one cycle after start; done in cycle 6 (normal) or 7 (MUL/DIV), plus extra T1 cycles with SEQ_MEM_WAIT_EN.
// Backpressure: start is ignored while busy; with SEQ_MEM_WAIT_EN the T1 step stalls until mem_ready.
module alu_op_sequencer #(
    parameter int                  NUM_REGS   = 16,
    parameter int                  REG_SEL_W  = 4,
    parameter int                  OPCODE_W   = 5,
    parameter logic [OPCODE_W-1:0] MUL_OPCODE = OPCODE_W'(5'b01110),
    parameter logic [OPCODE_W-1:0] DIV_OPCODE = OPCODE_W'(5'b01111)
) (
    input  logic              clock,
    input  logic              clear,
    alu_op_sequencer_if.slave bus
);

    localparam int RA_MSB  = 31 - OPCODE_W;
    localparam int RB_MSB  = RA_MSB - REG_SEL_W;
    localparam int RC_MSB  = RB_MSB - REG_SEL_W;
    localparam int LOW_MSB = RC_MSB - REG_SEL_W;

    typedef enum logic [2:0] {
        S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6
    } state_t;

    typedef struct packed {
        logic pc_out;
        logic mar_in;
        logic inc_pc;
        logic pc_in;
        logic read;
        logic mdr_in;
        logic mdr_out;
        logic ir_in;
        logic y_in;
        logic z_in;
        logic zlow_out;
        logic zhigh_out;
        logic lo_in;
        logic hi_in;
        logic busy;
        logic done;
    } ctl_t;

    state_t state_q, state_d;
    ctl_t   ctl_q, ctl_d;

    logic [OPCODE_W-1:0]  ir_opcode;
    logic [REG_SEL_W-1:0] ra_sel, rb_sel, rc_sel;
    logic                 is_muldiv;

    logic [NUM_REGS-1:0]  rin_o, rout_o;
    logic [OPCODE_W-1:0]  opcode_o;

    assign ir_opcode = bus.ir[31 -: OPCODE_W];
    assign ra_sel    = bus.ir[RA_MSB -: REG_SEL_W];
    assign rb_sel    = bus.ir[RB_MSB -: REG_SEL_W];
    assign rc_sel    = bus.ir[RC_MSB -: REG_SEL_W];
    assign is_muldiv = (ir_opcode == MUL_OPCODE) || (ir_opcode == DIV_OPCODE);

    // Selectors beyond NUM_REGS decode to no enable at all rather than aliasing.
    function automatic logic [NUM_REGS-1:0] onehot(input logic [REG_SEL_W-1:0] sel);
        logic [NUM_REGS-1:0] v;
        v = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            v[i] = (int'(sel) == i);
        end
        return v;
    endfunction

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (bus.start) state_d = S_T0;
            S_T0:   state_d = S_T1;
`ifdef SEQ_MEM_WAIT_EN
            S_T1:   if (bus.mem_ready) state_d = S_T2;
`else
            S_T1:   state_d = S_T2;
`endif
            S_T2:   state_d = S_T3;
            S_T3:   state_d = S_T4;
            S_T4:   state_d = S_T5;
            S_T5:   state_d = is_muldiv ? S_T6 : S_IDLE;
            S_T6:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Strobes are decoded from the next state so they come straight off flops in the step they belong to.
    always_comb begin
        ctl_d      = '0;
        ctl_d.busy = (state_d != S_IDLE);
        case (state_d)
            S_T0: begin
                ctl_d.pc_out = 1'b1;
                ctl_d.mar_in = 1'b1;
                ctl_d.inc_pc = 1'b1;
                ctl_d.z_in   = 1'b1;
            end
            S_T1: begin
                ctl_d.zlow_out = 1'b1;
                ctl_d.pc_in    = (state_q == S_T0);
                ctl_d.read     = 1'b1;
                ctl_d.mdr_in   = 1'b1;
            end
            S_T2: begin
                ctl_d.mdr_out = 1'b1;
                ctl_d.ir_in   = 1'b1;
            end
            S_T3: ctl_d.y_in = 1'b1;
            S_T4: ctl_d.z_in = 1'b1;
            S_T5: begin
                ctl_d.zlow_out = 1'b1;
                ctl_d.lo_in    = is_muldiv;
                ctl_d.done     = !is_muldiv;
            end
            S_T6: begin
                ctl_d.zhigh_out = 1'b1;
                ctl_d.hi_in     = 1'b1;
                ctl_d.done      = 1'b1;
            end
            default: ctl_d = '0;
        endcase
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_q <= S_IDLE;
            ctl_q   <= '0;
        end else begin
            state_q <= state_d;
            ctl_q   <= ctl_d;
        end
    end

    // Register fields come from the IR loaded at the end of T2, so they are decoded live from the state.
    always_comb begin
        rin_o    = '0;
        rout_o   = '0;
        opcode_o = '0;
        case (state_q)
            S_T3: rout_o = onehot(rb_sel);
            S_T4: begin
                rout_o   = onehot(rc_sel);
                opcode_o = ir_opcode;
            end
            S_T5: if (!is_muldiv) rin_o = onehot(ra_sel);
            default: ;
        endcase
    end

    assign bus.rin       = rin_o;
    assign bus.rout      = rout_o;
    assign bus.opcode    = opcode_o;
    assign bus.pc_out    = ctl_q.pc_out;
    assign bus.mar_in    = ctl_q.mar_in;
    assign bus.inc_pc    = ctl_q.inc_pc;
    assign bus.pc_in     = ctl_q.pc_in;
    assign bus.read      = ctl_q.read;
    assign bus.mdr_in    = ctl_q.mdr_in;
    assign bus.mdr_out   = ctl_q.mdr_out;
    assign bus.ir_in     = ctl_q.ir_in;
    assign bus.y_in      = ctl_q.y_in;
    assign bus.z_in      = ctl_q.z_in;
    assign bus.zlow_out  = ctl_q.zlow_out;
    assign bus.zhigh_out = ctl_q.zhigh_out;
    assign bus.lo_in     = ctl_q.lo_in;
    assign bus.hi_in     = ctl_q.hi_in;
    assign bus.busy      = ctl_q.busy;
    assign bus.done      = ctl_q.done;

    logic unused_ir_low;
    assign unused_ir_low = ^bus.ir[LOW_MSB:0];
`ifndef SEQ_MEM_WAIT_EN
    logic unused_mem_ready;
    assign unused_mem_ready = bus.mem_ready;
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer: table of instructions checked step by step, plus hand sequences
// for async clear, ignored start pulses, out-of-range selectors (NUM_REGS=8 copy) and the memory wait.
module tb_alu_op_sequencer;

    logic clock = 1'b0;
    logic clear = 1'b1;
    always #5 clock = ~clock;

    alu_op_sequencer_if #(.NUM_REGS(16), .OPCODE_W(5)) bus ();
    alu_op_sequencer_if #(.NUM_REGS(8),  .OPCODE_W(5)) bus8 ();

    assign bus8.start     = bus.start;
    assign bus8.ir        = bus.ir;
    assign bus8.mem_ready = bus.mem_ready;

    alu_op_sequencer #(.NUM_REGS(16)) u_dut  (.clock(clock), .clear(clear), .bus(bus.slave));
    alu_op_sequencer #(.NUM_REGS(8))  u_dut8 (.clock(clock), .clear(clear), .bus(bus8.slave));

    typedef struct {
        string       name;
        logic [31:0] ir;
        logic [15:0] ra_oh;
        logic [15:0] rb_oh;
        logic [15:0] rc_oh;
        logic [4:0]  op;
        logic        muldiv;
    } vec_t;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input string n, input logic [4:0] op, input logic [3:0] ra,
                                input logic [3:0] rb, input logic [3:0] rc, input logic [15:0] ea,
                                input logic [15:0] eb, input logic [15:0] ec, input logic md);
        vec_t v;
        v.name = n; v.ir = {op, ra, rb, rc, 15'b0};
        v.ra_oh = ea; v.rb_oh = eb; v.rc_oh = ec; v.op = op; v.muldiv = md;
        return v;
    endfunction

    function automatic logic [52:0] obs16();
        return {bus.rin, bus.rout, bus.opcode, bus.pc_out, bus.mar_in, bus.inc_pc, bus.pc_in,
                bus.read, bus.mdr_in, bus.mdr_out, bus.ir_in, bus.y_in, bus.z_in, bus.zlow_out,
                bus.zhigh_out, bus.lo_in, bus.hi_in, bus.busy, bus.done};
    endfunction

    // Expected outputs of each control step, written out from the step table.
    function automatic logic [52:0] exp_obs(input int s, input vec_t v);
        logic [15:0] rin, rout;
        logic [4:0]  op;
        logic pc_out, mar_in, inc_pc, pc_in, read, mdr_in, mdr_out, ir_in, y_in, z_in;
        logic zlow_out, zhigh_out, lo_in, hi_in, busy, done;
        rin = '0; rout = '0; op = '0;
        {pc_out, mar_in, inc_pc, pc_in, read, mdr_in, mdr_out, ir_in, y_in, z_in} = '0;
        {zlow_out, zhigh_out, lo_in, hi_in, done} = '0;
        busy = 1'b1;
        case (s)
            0: begin pc_out = 1; mar_in = 1; inc_pc = 1; z_in = 1; end
            1: begin zlow_out = 1; pc_in = 1; read = 1; mdr_in = 1; end
            2: begin mdr_out = 1; ir_in = 1; end
            3: begin rout = v.rb_oh; y_in = 1; end
            4: begin rout = v.rc_oh; z_in = 1; op = v.op; end
            5: begin
                zlow_out = 1;
                if (v.muldiv) lo_in = 1;
                else begin rin = v.ra_oh; done = 1; end
            end
            6: begin zhigh_out = 1; hi_in = 1; done = 1; end
            default: busy = 1'b0;
        endcase
        return {rin, rout, op, pc_out, mar_in, inc_pc, pc_in, read, mdr_in, mdr_out, ir_in, y_in,
                z_in, zlow_out, zhigh_out, lo_in, hi_in, busy, done};
    endfunction

    task automatic run_vec(input vec_t v);
        int n;
        n = v.muldiv ? 7 : 6;
        @(negedge clock);
        bus.ir = v.ir; bus.start = 1'b1; bus.mem_ready = 1'b1;
        for (int s = 0; s < n; s++) begin
            @(negedge clock);
            bus.start = 1'b0;
            check($sformatf("%s_T%0d", v.name, s), obs16(), exp_obs(s, v));
        end
        @(negedge clock);
        check($sformatf("%s_idle", v.name), obs16(), 53'd0);
    endtask

    vec_t vecs[6];

    initial begin
        int done_cnt, done8_cnt, lat, pc_cnt, rd_cnt, exp_lat, exp_rd;

        vecs[0] = mk("or_r4_r3_r7",  5'b00110, 4'd4,  4'd3,  4'd7,  16'h0010, 16'h0008, 16'h0080, 1'b0);
        vecs[1] = mk("mul_r0_r1_r2", 5'b01110, 4'd0,  4'd1,  4'd2,  16'h0001, 16'h0002, 16'h0004, 1'b1);
        vecs[2] = mk("div_r15_r14",  5'b01111, 4'd15, 4'd14, 4'd15, 16'h8000, 16'h4000, 16'h8000, 1'b1);
        vecs[3] = mk("add_r9_same",  5'b00011, 4'd9,  4'd9,  4'd9,  16'h0200, 16'h0200, 16'h0200, 1'b0);
        vecs[4] = mk("sub_r0_r15",   5'b00100, 4'd0,  4'd15, 4'd1,  16'h0001, 16'h8000, 16'h0002, 1'b0);
        vecs[5] = mk("op01101",      5'b01101, 4'd5,  4'd6,  4'd0,  16'h0020, 16'h0040, 16'h0001, 1'b0);

        bus.start = 1'b0; bus.ir = '0; bus.mem_ready = 1'b1;
        #2;
        check("reset_outputs", obs16(), 53'd0);
        repeat (2) @(negedge clock);
        clear = 1'b0;
        @(negedge clock);
        check("idle_after_reset", obs16(), 53'd0);

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // Clear in the middle of T3 kills the instruction at once.
        @(negedge clock);
        bus.ir = vecs[0].ir; bus.start = 1'b1;
        @(negedge clock); bus.start = 1'b0;
        repeat (3) @(negedge clock);
        check("clr_pre_T3_rout", 64'(bus.rout), 64'h0008);
        #1 clear = 1'b1;
        #1;
        check("clr_async_outputs", obs16(), 53'd0);
        check("clr_async_busy", 64'(bus.busy), 64'd0);
        @(negedge clock); clear = 1'b0;
        @(negedge clock);
        check("clr_idle_after", obs16(), 53'd0);
        run_vec(vecs[0]);

        // Start pulses in T2 and T4 are ignored; out-of-range selectors on the 8-register copy.
        @(negedge clock);
        bus.ir = {5'b00010, 4'd12, 4'd2, 4'd15, 15'b0}; bus.start = 1'b1;
        done_cnt = 0; done8_cnt = 0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clock);
            if (c == 4) begin
                check("nr8_T3_rout", 64'(bus8.rout), 64'h04);
                check("nr16_T3_rout", 64'(bus.rout), 64'h0004);
            end
            if (c == 5) begin
                check("nr8_T4_rout_oob", 64'(bus8.rout), 64'h00);
                check("nr16_T4_rout_r15", 64'(bus.rout), 64'h8000);
            end
            if (c == 6) begin
                check("nr8_T5_rin_oob", 64'(bus8.rin), 64'h00);
                check("nr8_T5_done", 64'(bus8.done), 64'd1);
                check("nr16_T5_rin_r12", 64'(bus.rin), 64'h1000);
            end
            if (bus.done)  done_cnt++;
            if (bus8.done) done8_cnt++;
            bus.start = (c == 3 || c == 5) ? 1'b1 : 1'b0;
        end
        check("busy_start_one_done", 64'(done_cnt), 64'd1);
        check("busy_start_one_done8", 64'(done8_cnt), 64'd1);
        check("busy_start_idle", 64'(bus.busy), 64'd0);

        // Start held in the final step does not chain into a new instruction.
        @(negedge clock);
        bus.ir = vecs[3].ir; bus.start = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clock);
            bus.start = (c == 6) ? 1'b1 : 1'b0;
        end
        @(negedge clock);
        check("no_chain_idle", 64'(bus.busy), 64'd0);
        bus.start = 1'b0;
        @(negedge clock);
        check("no_chain_still_idle", 64'(bus.busy), 64'd0);

        // Memory wait: mem_ready low for the first three T1 samples.
`ifdef SEQ_MEM_WAIT_EN
        exp_lat = 9; exp_rd = 4;
`else
        exp_lat = 6; exp_rd = 1;
`endif
        @(negedge clock);
        bus.ir = vecs[3].ir; bus.start = 1'b1; bus.mem_ready = 1'b0;
        lat = 0; pc_cnt = 0; rd_cnt = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clock);
            bus.start = 1'b0;
            if (bus.pc_in) pc_cnt++;
            if (bus.read)  rd_cnt++;
            if (c >= 5) bus.mem_ready = 1'b1;
            if (bus.done) begin
                lat = c;
                break;
            end
        end
        check("memwait_latency", 64'(lat), 64'(exp_lat));
        check("memwait_pc_in_once", 64'(pc_cnt), 64'd1);
        check("memwait_read_cycles", 64'(rd_cnt), 64'(exp_rd));
        @(negedge clock);
        check("memwait_idle", obs16(), 53'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
